// File: rtl/vmem_write_sched.sv
// Write-port scheduler for the 3-bit video memory: round-robin core writes plus a full-screen fill engine.
// Optional macro VMEM_FILL_YIELD_EN lets cores interleave with an active fill.
`ifndef NCORES
`define NCORES 4
`endif
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 4
`endif

module vmem_write_sched #(
  parameter int NCORES     = `NCORES,
  parameter int VMEM_ADDRW = `VMEM_ADDRW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            req_valid_i,
  output logic [NCORES-1:0]            req_ready_o,
  input  logic [VMEM_ADDRW*NCORES-1:0] req_addr_i,
  input  logic [3*NCORES-1:0]          req_wdata_i,
  input  logic                         fill_start_i,
  input  logic [2:0]                   fill_color_i,
  output logic                         fill_busy_o,
  output logic                         fill_done_o,
  output logic                         we_o,
  output logic [VMEM_ADDRW-1:0]        waddr_o,
  output logic [2:0]                   wdata_o
);

  localparam int VMEM_DEPTH = 1 << VMEM_ADDRW;
  localparam int PW = $clog2(NCORES);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  localparam logic [VMEM_ADDRW:0] LAST_ADDR = (VMEM_ADDRW+1)'(VMEM_DEPTH - 1);

  logic [0:0]            state;
  logic [PW-1:0]         ptr;
  logic [VMEM_ADDRW:0]   cnt;
  logic [2:0]            color;
  logic                  found;
  logic [PW-1:0]         gidx;
  logic [PW-1:0]         next_ptr;
  logic                  grant_en;
  logic                  core_grant;
  logic [VMEM_ADDRW-1:0] sel_addr;
  logic [2:0]            sel_data;

  // First valid core at or after the pointer, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int i = 0; i < NCORES; i++) begin
      idx = (int'(ptr) + i) % NCORES;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gidx  = PW'(idx);
      end
    end
  end

`ifdef VMEM_FILL_YIELD_EN
  logic yield_ok;
  assign grant_en = rst_ni && (((state == IDLE) && !fill_start_i) ||
                               ((state == FILL) && yield_ok));
`else
  assign grant_en = rst_ni && (state == IDLE) && !fill_start_i;
`endif

  assign core_grant  = grant_en && found;
  assign req_ready_o = core_grant ? (NCORES'(1) << gidx) : '0;
  assign next_ptr    = (gidx == PW'(NCORES - 1)) ? '0 : gidx + 1'b1;
  assign sel_addr    = req_addr_i[int'(gidx)*VMEM_ADDRW +: VMEM_ADDRW];
  assign sel_data    = req_wdata_i[int'(gidx)*3 +: 3];
  assign fill_busy_o = (state == FILL);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      color       <= '0;
      we_o        <= 1'b0;
      waddr_o     <= '0;
      wdata_o     <= '0;
      fill_done_o <= 1'b0;
`ifdef VMEM_FILL_YIELD_EN
      yield_ok    <= 1'b0;
`endif
    end else begin
      we_o        <= 1'b0;
      fill_done_o <= 1'b0;
      if (core_grant) begin
        we_o    <= 1'b1;
        waddr_o <= sel_addr;
        wdata_o <= sel_data;
        ptr     <= next_ptr;
      end
      case (state)
        IDLE: begin
          if (fill_start_i) begin
            state <= FILL;
            cnt   <= '0;
            color <= fill_color_i;
`ifdef VMEM_FILL_YIELD_EN
            yield_ok <= 1'b0;
`endif
          end
        end
        FILL: begin
          if (!core_grant) begin
            we_o    <= 1'b1;
            waddr_o <= cnt[VMEM_ADDRW-1:0];
            wdata_o <= color;
            cnt     <= cnt + 1'b1;
`ifdef VMEM_FILL_YIELD_EN
            yield_ok <= 1'b1;
`endif
            if (cnt == LAST_ADDR) begin
              state       <= IDLE;
              fill_done_o <= 1'b1;
            end
          end else begin
`ifdef VMEM_FILL_YIELD_EN
            yield_ok <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_write_sched.sv
// Randomized scoreboard bench for vmem_write_sched (NCORES=4, VMEM_ADDRW=4).
// The stimulus side models expected writes; a separate monitor checks the write port.
module tb_vmem_write_sched;

  localparam int N     = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [AW*N-1:0] req_addr = '0;
  logic [3*N-1:0]  req_wdata = '0;
  logic            fill_start = 1'b0;
  logic [2:0]      fill_color = '0;
  logic            fill_busy;
  logic            fill_done;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [2:0]      wdata;

  vmem_write_sched #(.NCORES(N), .VMEM_ADDRW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .fill_start_i(fill_start), .fill_color_i(fill_color),
    .fill_busy_o(fill_busy), .fill_done_o(fill_done),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    data;
    bit            done;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  // Per-core requester state.
  bit            pend[N];
  logic [AW-1:0] ca[N];
  logic [2:0]    cd[N];
  int            left[N];
  bit            rnd_mode = 1'b0;
  int            rnd_pct = 0;

  // Reference model: pointer, fill progress as plain integers.
  int         m_ptr = 0;
  bit         m_fill = 1'b0;
  int         m_addr = 0;
  logic [2:0] m_col = '0;
  bit         m_last_fill = 1'b0;
  int         fill_writes = 0;
  int         core_writes = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endfunction

  function automatic int arb();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step();
    int   g;
    wr_t  e;
    logic [31:0] exp_ready;
    chk("busy", {31'b0, fill_busy}, {31'b0, m_fill});
    if (!rst_n) begin
      chk("ready_in_reset", {28'b0, req_ready}, 32'd0);
      m_ptr = 0; m_fill = 1'b0; m_addr = 0; m_last_fill = 1'b0;
      return;
    end
    g = -1;
    if (!m_fill) begin
      if (fill_start) begin
        m_fill = 1'b1; m_addr = 0; m_col = fill_color; m_last_fill = 1'b0;
      end else begin
        g = arb();
      end
    end else begin
`ifdef VMEM_FILL_YIELD_EN
      if (m_last_fill) g = arb();
`endif
      if (g < 0) begin
        e.addr = AW'(m_addr); e.data = m_col; e.done = (m_addr == DEPTH - 1);
        exp_q.push_back(e);
        fill_writes++;
        m_addr++;
        m_last_fill = 1'b1;
        if (m_addr == DEPTH) m_fill = 1'b0;
      end else begin
        m_last_fill = 1'b0;
      end
    end
    exp_ready = 0;
    if (g >= 0) begin
      e.addr = ca[g]; e.data = cd[g]; e.done = 1'b0;
      exp_q.push_back(e);
      core_writes++;
      m_ptr = (g + 1) % N;
      pend[g] = 1'b0;
      exp_ready = 32'd1 << g;
    end
    chk("ready", {28'b0, req_ready}, exp_ready);
  endtask

  task automatic step(input bit rst_v, input bit start_v, input logic [2:0] col_v);
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      if (!pend[k]) begin
        if (left[k] > 0) begin
          left[k]--; pend[k] = 1'b1; ca[k] = AW'($urandom); cd[k] = 3'($urandom);
        end else if (rnd_mode && $urandom_range(99) < rnd_pct) begin
          pend[k] = 1'b1; ca[k] = AW'($urandom); cd[k] = 3'($urandom);
        end
      end
    end
    rst_n = rst_v;
    fill_start = start_v;
    fill_color = col_v;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = pend[k];
      req_addr[k*AW +: AW] = ca[k];
      req_wdata[k*3 +: 3] = cd[k];
    end
    #1;
    model_step();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0);
  endtask

  // Monitor: each cycle the write port must show exactly the queued write, or nothing.
  logic [AW-1:0] last_a = '0;
  logic [2:0]    last_d = '0;
  always @(posedge clk) begin
    logic r;
    wr_t  e;
    r = rst_n;
    #1;
    if (!r) begin
      chk("we_after_reset", {31'b0, we}, 32'd0);
      chk("waddr_after_reset", {28'b0, waddr}, 32'd0);
      chk("wdata_after_reset", {29'b0, wdata}, 32'd0);
      chk("done_after_reset", {31'b0, fill_done}, 32'd0);
      chk("busy_after_reset", {31'b0, fill_busy}, 32'd0);
      exp_q.delete();
      last_a = '0; last_d = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("we", {31'b0, we}, 32'd1);
      chk("waddr", {28'b0, waddr}, {28'b0, e.addr});
      chk("wdata", {29'b0, wdata}, {29'b0, e.data});
      chk("fill_done", {31'b0, fill_done}, {31'b0, e.done});
      if (e.done) chk("busy_at_done", {31'b0, fill_busy}, 32'd0);
      last_a = e.addr; last_d = e.data;
    end else begin
      chk("we_idle", {31'b0, we}, 32'd0);
      chk("fill_done_idle", {31'b0, fill_done}, 32'd0);
      chk("waddr_hold", {28'b0, waddr}, {28'b0, last_a});
      chk("wdata_hold", {29'b0, wdata}, {29'b0, last_d});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fw0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0; ca[k] = '0; cd[k] = '0; left[k] = 0;
    end

    // Reset with every core requesting, then the round-robin walk.
    rnd_mode = 1'b1; rnd_pct = 100;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0);
    idle_steps(5);
    rnd_mode = 1'b0;
    idle_steps(6);

    // Single request from core 2.
    pend[2] = 1'b1; ca[2] = 4'd5; cd[2] = 3'b110;
    idle_steps(4);

    // Plain fill, then a new fill started in the done cycle.
    step(1'b1, 1'b1, 3'b011);
    idle_steps(20);
    step(1'b1, 1'b1, 3'b101);
    for (int i = 0; i < 40 && m_fill; i++) step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'b010);
    idle_steps(20);

    // Fill and cores 1,3 arriving together.
    pend[1] = 1'b1; ca[1] = 4'd9;  cd[1] = 3'd1;
    pend[3] = 1'b1; ca[3] = 4'd12; cd[3] = 3'd7;
    step(1'b1, 1'b1, 3'b100);
    idle_steps(24);

    // Reset just as address 7 is due, then a fresh fill.
    step(1'b1, 1'b1, 3'b111);
    for (int i = 0; i < 20 && !(m_fill && m_addr == 7); i++) step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'b001);
    idle_steps(20);

    // Core 0 issues three requests during a fill.
    fw0 = fill_writes;
    left[0] = 3;
    step(1'b1, 1'b1, 3'b110);
    idle_steps(25);
    chk("fill_write_count", fill_writes - fw0, DEPTH);

    // Random traffic with occasional fills and resets.
    rnd_mode = 1'b1; rnd_pct = 40;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(249) == 0)
        step(1'b0, 1'b0, 3'd0);
      else
        step(1'b1, ($urandom_range(39) == 0), 3'($urandom));
    end
    rnd_mode = 1'b0;
    idle_steps(40);

    @(posedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
